// File: rtl/sysid_checker_master_pkg.sv
// ============================================================================
// sysid_checker_master_pkg
// Shared FSM encoding and sysid word addresses for the sysid slave and checker.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sysid_checker_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic ADDR_ID        = 1'b0;
    localparam logic ADDR_TIMESTAMP = 1'b1;
    localparam int   STALL_CNT_W    = 16;

endpackage

`default_nettype wire

// File: rtl/sysid_checker_master_stall_timer.sv
// ============================================================================
// avm_stall_timer
// Counts waitrequest-stalled cycles and flags when the limit has been reached.
// Revision: 1.0
// ============================================================================
`default_nettype none

module avm_stall_timer
    import sysid_checker_master_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [STALL_CNT_W-1:0] limit,
    output logic                   expired
);

    logic [STALL_CNT_W-1:0] count;

    // Saturates so a stuck enable can never wrap back below the limit.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != {STALL_CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= limit);

endmodule

`default_nettype wire

// File: rtl/sysid_checker_master.sv
// ============================================================================
// sysid_checker_master
// Reads the sysid ID and timestamp words over Avalon-MM and reports a match.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sysid_checker_master
    import sysid_checker_master_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1764163446,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [STALL_CNT_W-1:0] LIMIT = STALL_CNT_W'(TIMEOUT_CYCLES);

    state_t state;
    logic   auto_pending;
    logic   in_read;
    logic   launch;
    logic   accept;
    logic   expired;

    assign in_read = (state == ST_RD_ID) || (state == ST_RD_TS);
    assign launch  = ((state == ST_IDLE) || (state == ST_DONE)) && (start || auto_pending);
    assign accept  = in_read && !avm_waitrequest;

    avm_stall_timer u_stall_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (launch || accept || (in_read && expired)),
        .enable  (in_read && avm_waitrequest && !expired),
        .limit   (LIMIT),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            auto_pending <= AUTO_START;
            avm_address  <= ADDR_ID;
            avm_read     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            id_ok        <= 1'b0;
            ts_ok        <= 1'b0;
            timeout      <= 1'b0;
            id_value     <= '0;
            ts_value     <= '0;
        end else begin
            auto_pending <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        state       <= ST_RD_ID;
                        avm_address <= ADDR_ID;
                        avm_read    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout     <= 1'b0;
                        id_value    <= '0;
                        ts_value    <= '0;
                    end
                end
                ST_RD_ID: begin
                    // An ID mismatch still proceeds to the timestamp read.
                    if (!avm_waitrequest) begin
                        state       <= ST_RD_TS;
                        avm_address <= ADDR_TIMESTAMP;
                        id_value    <= avm_readdata;
                        id_ok       <= (avm_readdata == EXPECTED_ID);
                    end else if (expired) begin
                        state       <= ST_DONE;
                        avm_address <= ADDR_ID;
                        avm_read    <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout     <= 1'b1;
                    end
                end
                ST_RD_TS: begin
                    if (!avm_waitrequest || expired) begin
                        state       <= ST_DONE;
                        avm_address <= ADDR_ID;
                        avm_read    <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        ts_value <= avm_readdata;
                        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
                        pass     <= id_ok && (avm_readdata == EXPECTED_TIMESTAMP);
                    end else if (expired) begin
                        timeout  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sysid_checker_master.sv
// ============================================================================
// tb_sysid_checker_master
// Randomized and directed checking of sysid_checker_master against a reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sysid_checker_master;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1764163446;
    localparam int          TMO    = 8;

    logic        clock;
    logic        reset;
    logic        start;
    logic        wr;
    logic [31:0] rd;
    logic [31:0] id_word;
    logic [31:0] ts_word;
    logic        avm_address, avm_read, busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    logic        reset_a;
    logic        start_a;
    logic        wr_a;
    logic [31:0] rd_a;
    logic        a_address, a_read, a_busy, a_done, a_pass, a_id_ok, a_ts_ok, a_timeout;
    logic [31:0] a_id_value, a_ts_value;

    int checks = 0;
    int errors = 0;

    sysid_checker_master #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(wr), .avm_readdata(rd),
        .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
        .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
    );

    sysid_checker_master #(.AUTO_START(1'b1)) dut_a (
        .clock(clock), .reset(reset_a), .start(start_a),
        .avm_address(a_address), .avm_read(a_read),
        .avm_waitrequest(wr_a), .avm_readdata(rd_a),
        .busy(a_busy), .done(a_done), .pass(a_pass), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
        .timeout(a_timeout), .id_value(a_id_value), .ts_value(a_ts_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave responders: the word returned depends only on the address presented.
    always_comb rd   = avm_address ? ts_word : id_word;
    always_comb rd_a = a_address ? EXP_TS : EXP_ID;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Reference model: phase 0 idle, 1 reading ID, 2 reading timestamp, 3 finished.
    int          m_phase = 0;
    int          m_stall = 0;
    logic [31:0] m_idv = 0, m_tsv = 0;
    bit          m_idok = 0, m_tsok = 0, m_to = 0, m_done = 0, m_pass = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0; m_stall = 0; m_idv = 0; m_tsv = 0;
            m_idok = 0; m_tsok = 0; m_to = 0; m_done = 0; m_pass = 0;
        end else if (m_phase == 0 || m_phase == 3) begin
            if (start) begin
                m_phase = 1; m_stall = 0; m_idv = 0; m_tsv = 0;
                m_idok = 0; m_tsok = 0; m_to = 0; m_done = 0; m_pass = 0;
            end
        end else if (!wr) begin
            if (m_phase == 1) begin
                m_idv = rd; m_idok = (rd == EXP_ID); m_phase = 2;
            end else begin
                m_tsv = rd; m_tsok = (rd == EXP_TS); m_phase = 3;
                m_done = 1; m_pass = m_idok && m_tsok;
            end
            m_stall = 0;
        end else if (m_stall >= TMO) begin
            m_to = 1; m_phase = 3; m_done = 1; m_pass = 0; m_stall = 0;
        end else begin
            m_stall++;
        end
        #1;
        chk("busy",     busy,        32'(m_phase == 1 || m_phase == 2));
        chk("avm_read", avm_read,    32'(m_phase == 1 || m_phase == 2));
        chk("avm_addr", avm_address, 32'(m_phase == 2));
        chk("done",     done,        32'(m_done));
        chk("pass",     pass,        32'(m_pass));
        chk("id_ok",    id_ok,       32'(m_idok));
        chk("ts_ok",    ts_ok,       32'(m_tsok));
        chk("timeout",  timeout,     32'(m_to));
        chk("id_value", id_value,    m_idv);
        chk("ts_value", ts_value,    m_tsv);
    end

    initial begin
        int stuck_left;
        reset = 1'b1; start = 1'b0; wr = 1'b0; id_word = EXP_ID; ts_word = EXP_TS;
        reset_a = 1'b1; start_a = 1'b0; wr_a = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        tick();

        // Zero-wait good sequence.
        start = 1'b1; tick(); start = 1'b0;
        chk("ok_c1_read", avm_read, 1);
        chk("ok_c1_addr", avm_address, 0);
        tick();
        chk("ok_c2_addr", avm_address, 1);
        chk("ok_c2_done", done, 0);
        tick();
        chk("ok_c3_done", done, 1);
        chk("ok_c3_pass", pass, 1);
        chk("ok_c3_idok", id_ok, 1);
        chk("ok_c3_tsok", ts_ok, 1);

        // ID mismatch still reads the timestamp.
        id_word = 32'h5;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("idbad_done", done, 1);
        chk("idbad_idok", id_ok, 0);
        chk("idbad_tsok", ts_ok, 1);
        chk("idbad_pass", pass, 0);
        chk("idbad_idval", id_value, 32'h5);
        id_word = EXP_ID;

        // Four stall cycles on each read: done after 11 cycles.
        start = 1'b1; wr = 1'b1;
        for (int p = 2; p <= 11; p++) begin
            tick(); start = 1'b0;
            wr = (p == 6 || p == 11) ? 1'b0 : 1'b1;
        end
        chk("stall_c10_done", done, 0);
        tick();
        chk("stall_c11_done", done, 1);
        chk("stall_c11_pass", pass, 1);
        wr = 1'b0;

        // Timeout with waitrequest stuck high during the timestamp read.
        ts_word = 32'hDEAD_BEEF;
        start = 1'b1; wr = 1'b0;
        for (int p = 2; p <= 11; p++) begin
            tick(); start = 1'b0;
            wr = (p == 2) ? 1'b0 : 1'b1;
        end
        chk("tmo_c10_read", avm_read, 1);
        chk("tmo_c10_tmo", timeout, 0);
        tick();
        chk("tmo_read", avm_read, 0);
        chk("tmo_flag", timeout, 1);
        chk("tmo_done", done, 1);
        chk("tmo_pass", pass, 0);
        chk("tmo_tsval", ts_value, 0);
        chk("tmo_idok", id_ok, 1);
        wr = 1'b0; ts_word = EXP_TS;

        // Reset during a stalled ID read.
        start = 1'b1; wr = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0; wr = 1'b0;
        chk("midrst_read", avm_read, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);

        // Start held during busy must not restart the sequence.
        start = 1'b1; tick(); tick(); start = 1'b0; tick();
        chk("rebusy_done", done, 1);
        chk("rebusy_pass", pass, 1);
        tick();
        chk("rebusy_idle", busy, 0);

        // Randomized traffic.
        stuck_left = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            reset = ($urandom_range(299) == 0);
            start = ($urandom_range(5) == 0);
            if (stuck_left > 0) begin
                wr = 1'b1; stuck_left--;
            end else if ($urandom_range(39) == 0) begin
                wr = 1'b1; stuck_left = 12;
            end else begin
                wr = ($urandom_range(2) == 0);
            end
            id_word = ($urandom_range(3) == 0) ? $urandom : EXP_ID;
            ts_word = ($urandom_range(3) == 0) ? $urandom : EXP_TS;
        end
        reset = 1'b0; start = 1'b0; wr = 1'b0;
        repeat (20) tick();

        // Automatic start on the first cycle after reset release.
        chk("auto_rst_busy", a_busy, 0);
        reset_a = 1'b0; tick();
        chk("auto_busy", a_busy, 1);
        chk("auto_read", a_read, 1);
        chk("auto_addr", a_address, 0);
        tick(); tick();
        chk("auto_done", a_done, 1);
        chk("auto_pass", a_pass, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
